// File: rtl/row_shift_writer_pkg.sv
// -----------------------------------------------------------------------------
// row_shift_writer_pkg
//
// Shared constants for the row/key serial configuration writer:
//   - default values of the writer parameters (row count, key width, serial
//     clock divider),
//   - the configuration FSM state encoding,
//   - a small helper that tells whether a state is timed by the half-period
//     timer.
// No ports; imported by the interface and all writer modules.
// -----------------------------------------------------------------------------
package row_shift_writer_pkg;

   // Default parameter values of the writer.
   localparam int DEF_N_ROWS  = 24;  // row bits per configuration frame
   localparam int DEF_KEY_W   = 8;   // key word width
   localparam int DEF_CLK_DIV = 4;   // system cycles per serial half-period

   // Configuration FSM states. Encodings are fixed so that waveforms and any
   // debug readback stay stable across builds.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ROW_LO   = 3'd1,
      ST_ROW_HI   = 3'd2,
      ST_KEY_LO   = 3'd3,
      ST_KEY_HI   = 3'd4,
      ST_LATCH    = 3'd5,
      ST_KEY_DONE = 3'd6
   } state_e;

   // True for the states whose length is one serial half-period; these are
   // the states that consume the half-period timer tick.
   function automatic logic is_timed(input state_e s);
      return (s == ST_ROW_LO) || (s == ST_ROW_HI) ||
             (s == ST_KEY_LO) || (s == ST_KEY_HI) ||
             (s == ST_LATCH);
   endfunction

endpackage : row_shift_writer_pkg

// File: rtl/row_shift_writer_if.sv
// -----------------------------------------------------------------------------
// row_shift_writer_if
//
// Request/status bus between a controller and the row_shift_writer.
// Signal names are seen from the writer side (i_* into the writer, o_* out).
//
//   i_row_wren        one-cycle request to send one row bit
//   i_row_val         row bit value, sampled with i_row_wren
//   i_key_wren        one-cycle request to send the key and latch
//   i_key[KEY_W]      key word, sampled with i_key_wren
//   o_write_done      writer idle and ready for a request
//   o_key_write_done  one-cycle pulse at the end of a key sequence
//   o_overrun         sticky: a request arrived while busy or collided
//   o_len_err         sticky: key requested after a wrong row-bit count
//
// Modports: master = controller, slave = writer.
// -----------------------------------------------------------------------------
interface row_shift_writer_if
   import row_shift_writer_pkg::*;
#(
   parameter int KEY_W = DEF_KEY_W
);

   logic             i_row_wren;
   logic             i_row_val;
   logic             i_key_wren;
   logic [KEY_W-1:0] i_key;
   logic             o_write_done;
   logic             o_key_write_done;
   logic             o_overrun;
   logic             o_len_err;

   modport master (
      output i_row_wren,
      output i_row_val,
      output i_key_wren,
      output i_key,
      input  o_write_done,
      input  o_key_write_done,
      input  o_overrun,
      input  o_len_err
   );

   modport slave (
      input  i_row_wren,
      input  i_row_val,
      input  i_key_wren,
      input  i_key,
      output o_write_done,
      output o_key_write_done,
      output o_overrun,
      output o_len_err
   );

endinterface : row_shift_writer_if

// File: rtl/row_shift_writer_half_period_timer.sv
// -----------------------------------------------------------------------------
// half_period_timer
//
// Down-counter that measures one serial half-period of CLK_DIV system cycles.
// A load arms it for a fresh half-period; tick_o is high during the last
// cycle of that half-period. Loading in the same cycle as the tick starts the
// next half-period back to back, so consecutive phases are exactly CLK_DIV
// cycles each.
//
//   clk     system clock
//   rst_n   asynchronous active-low reset (counter to 0)
//   load_i  start a new half-period on the next cycle
//   tick_o  last cycle of the current half-period
// -----------------------------------------------------------------------------
module half_period_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   output logic tick_o
);

   localparam int               CNT_W  = $clog2(CLK_DIV) + 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // NOTE: cnt_d gets a default before any branch so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: registers are written with non-blocking assignments so every
   // flop samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counter parks at zero when not reloaded, so the tick never wraps.
   assign tick_o = (cnt_q == '0);

endmodule : half_period_timer

// File: rtl/row_shift_writer.sv
// -----------------------------------------------------------------------------
// row_shift_writer
//
// Serialises configuration data into a sensor over a three-wire interface
// (serial clock, serial data, load strobe).
//
//   Row request: one bit is driven on o_sdata for one serial clock period
//   (CLK_DIV cycles low, CLK_DIV cycles high). Accepted row bits are counted.
//   Key request: KEY_W bits are shifted MSB first, then o_latch is pulsed for
//   one half-period and o_key_write_done pulses for one cycle. A key accepted
//   after a row count other than N_ROWS sets the sticky o_len_err; the row
//   count restarts once the key sequence completes.
//   Any request that cannot be accepted sets the sticky o_overrun.
//
// Ports
//   clk            system clock (single domain)
//   rst_n          asynchronous active-low reset
//   bus            row_shift_writer_if.slave request/status bus
//   o_sclk         sensor serial clock
//   o_sdata        sensor serial data (holds its last value in idle)
//   o_latch        sensor load strobe
// -----------------------------------------------------------------------------
module row_shift_writer
   import row_shift_writer_pkg::*;
#(
   parameter int N_ROWS  = DEF_N_ROWS,
   parameter int KEY_W   = DEF_KEY_W,
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic                clk,
   input  logic                rst_n,
   row_shift_writer_if.slave   bus,
   output logic                o_sclk,
   output logic                o_sdata,
   output logic                o_latch
);

   // Row counter saturates at N_ROWS+1 so an over-long frame never wraps
   // back to a count that looks correct.
   localparam int                   ROW_CNT_W = $clog2(N_ROWS + 2);
   localparam logic [ROW_CNT_W-1:0] ROW_SAT   = ROW_CNT_W'(N_ROWS + 1);
   localparam logic [ROW_CNT_W-1:0] ROW_FULL  = ROW_CNT_W'(N_ROWS);

   localparam int                   BIT_W     = $clog2(KEY_W) + 1;
   localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(KEY_W - 1);

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   state_e                 state_q;
   logic                   sclk_q;
   logic                   sdata_q;
   logic                   latch_q;
   logic                   key_done_q;
   logic                   overrun_q;
   logic                   len_err_q;
   logic [ROW_CNT_W-1:0]   row_cnt_q;
   logic [BIT_W-1:0]       bit_idx_q;
   logic [KEY_W-1:0]       shift_q;     // key bits not yet driven, MSB next

   // ---------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------
   logic in_idle;
   logic any_req;
   logic accept_row;
   logic accept_key;
   logic reject;
   logic tick;
   logic timer_load;

   assign in_idle    = (state_q == ST_IDLE);
   assign any_req    = bus.i_row_wren | bus.i_key_wren;
   // A row request wins over a simultaneous key request.
   assign accept_row = in_idle & bus.i_row_wren;
   assign accept_key = in_idle & bus.i_key_wren & ~bus.i_row_wren;
   assign reject     = (any_req & ~in_idle) |
                       (in_idle & bus.i_row_wren & bus.i_key_wren);

   // Arm the timer when a sequence starts and at every phase boundary.
   assign timer_load = accept_row | accept_key | (is_timed(state_q) & tick);

   half_period_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (timer_load),
      .tick_o (tick)
   );

   // ---------------------------------------------------------------------
   // Configuration FSM with registered serial outputs
   // ---------------------------------------------------------------------
   // NOTE: the key shift register and other datapath registers are reset
   // along with the control state so a reset always leaves the serial pins
   // in a known, quiet condition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sclk_q     <= 1'b0;
         sdata_q    <= 1'b0;
         latch_q    <= 1'b0;
         key_done_q <= 1'b0;
         row_cnt_q  <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sclk_q  <= 1'b0;
               latch_q <= 1'b0;
               if (accept_row) begin
                  sdata_q <= bus.i_row_val;
                  state_q <= ST_ROW_LO;
                  if (row_cnt_q != ROW_SAT) begin
                     row_cnt_q <= row_cnt_q + ROW_CNT_W'(1);
                  end
               end else if (accept_key) begin
                  // First key bit goes out now; the rest wait in shift_q.
                  sdata_q   <= bus.i_key[KEY_W-1];
                  shift_q   <= bus.i_key << 1;
                  bit_idx_q <= '0;
                  state_q   <= ST_KEY_LO;
               end
            end

            ST_ROW_LO: begin
               if (tick) begin
                  sclk_q  <= 1'b1;
                  state_q <= ST_ROW_HI;
               end
            end

            ST_ROW_HI: begin
               if (tick) begin
                  sclk_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end

            ST_KEY_LO: begin
               if (tick) begin
                  sclk_q  <= 1'b1;
                  state_q <= ST_KEY_HI;
               end
            end

            ST_KEY_HI: begin
               if (tick) begin
                  sclk_q <= 1'b0;
                  if (bit_idx_q == BIT_LAST) begin
                     latch_q <= 1'b1;
                     state_q <= ST_LATCH;
                  end else begin
                     sdata_q   <= shift_q[KEY_W-1];
                     shift_q   <= shift_q << 1;
                     bit_idx_q <= bit_idx_q + BIT_W'(1);
                     state_q   <= ST_KEY_LO;
                  end
               end
            end

            ST_LATCH: begin
               if (tick) begin
                  latch_q    <= 1'b0;
                  key_done_q <= 1'b1;
                  state_q    <= ST_KEY_DONE;
               end
            end

            ST_KEY_DONE: begin
               key_done_q <= 1'b0;
               row_cnt_q  <= '0;
               bit_idx_q  <= '0;
               state_q    <= ST_IDLE;
            end

            default: begin
               sclk_q     <= 1'b0;
               latch_q    <= 1'b0;
               key_done_q <= 1'b0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Sticky error flags; cleared only by reset
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         if (reject) begin
            overrun_q <= 1'b1;
         end
         if (accept_key && (row_cnt_q != ROW_FULL)) begin
            len_err_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.o_write_done     = in_idle;
   assign bus.o_key_write_done = key_done_q;
   assign bus.o_overrun        = overrun_q;
   assign bus.o_len_err        = len_err_q;
   assign o_sclk               = sclk_q;
   assign o_sdata              = sdata_q;
   assign o_latch              = latch_q;

endmodule : row_shift_writer

// File: tb/tb_row_shift_writer.sv
// -----------------------------------------------------------------------------
// tb_row_shift_writer
//
// Directed bench for row_shift_writer with CLK_DIV=2, N_ROWS=4, KEY_W=4.
// Inputs change and outputs are sampled on the falling clock edge; "t<k>"
// below is the k-th cycle after the cycle in which a request was presented.
// -----------------------------------------------------------------------------
module tb_row_shift_writer;

   localparam int N_ROWS  = 4;
   localparam int KEY_W   = 4;
   localparam int CLK_DIV = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sclk;
   logic sdata;
   logic latch;

   int n_tests  = 0;
   int n_failed = 0;

   row_shift_writer_if #(.KEY_W(KEY_W)) bus ();

   row_shift_writer #(
      .N_ROWS  (N_ROWS),
      .KEY_W   (KEY_W),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .o_sclk  (sclk),
      .o_sdata (sdata),
      .o_latch (latch)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic idle_inputs();
      bus.i_row_wren = 1'b0;
      bus.i_row_val  = 1'b0;
      bus.i_key_wren = 1'b0;
      bus.i_key      = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Bounded wait for o_write_done; an expired bound is a failed comparison.
   task automatic wait_idle(input string tag);
      int k = 0;
      while (!bus.o_write_done && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (bus.o_write_done !== 1'b1) begin
         n_failed++;
         $display("FAIL %s wait_idle: o_write_done=%b after %0d cycles, required 1", tag, bus.o_write_done, k);
      end
   endtask

   // Each pulse task returns at the sample point of t1.
   task automatic pulse_row(input logic val);
      bus.i_row_wren = 1'b1;
      bus.i_row_val  = val;
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic pulse_key(input logic [KEY_W-1:0] key);
      bus.i_key_wren = 1'b1;
      bus.i_key      = key;
      @(negedge clk);
      idle_inputs();
   endtask

   // Observes ncycles cycles starting at the current sample point: records
   // o_sdata at each rising o_sclk, counts latch cycles and done pulses.
   task automatic capture(input int ncycles, output logic [15:0] bits, output int nbits,
                          output int latch_cnt, output int kwd_cnt, output int kwd_at);
      logic prev = 1'b0;
      bits      = '0;
      nbits     = 0;
      latch_cnt = 0;
      kwd_cnt   = 0;
      kwd_at    = -1;
      for (int k = 1; k <= ncycles; k++) begin
         if (sclk && !prev) begin
            bits = {bits[14:0], sdata};
            nbits++;
         end
         prev = sclk;
         if (latch) latch_cnt++;
         if (bus.o_key_write_done) begin
            kwd_cnt++;
            kwd_at = k;
         end
         @(negedge clk);
      end
   endtask

   task automatic send_rows(input int count, input logic [7:0] vals, output logic [7:0] seen);
      logic [15:0] b;
      int nb, lc, kc, ka;
      seen = '0;
      for (int i = count - 1; i >= 0; i--) begin
         wait_idle("send_rows");
         pulse_row(vals[i]);
         capture(2 * CLK_DIV, b, nb, lc, kc, ka);
         seen = {seen[6:0], b[0]};
      end
   endtask

   // ---------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #3;
      n_tests += 7;
      if (bus.o_write_done !== 1'b1) begin n_failed++; $display("FAIL reset write_done: got %b need 1", bus.o_write_done); end
      if (sclk !== 1'b0)  begin n_failed++; $display("FAIL reset sclk: got %b need 0", sclk); end
      if (sdata !== 1'b0) begin n_failed++; $display("FAIL reset sdata: got %b need 0", sdata); end
      if (latch !== 1'b0) begin n_failed++; $display("FAIL reset latch: got %b need 0", latch); end
      if (bus.o_key_write_done !== 1'b0) begin n_failed++; $display("FAIL reset key_done: got %b need 0", bus.o_key_write_done); end
      if (bus.o_overrun !== 1'b0) begin n_failed++; $display("FAIL reset overrun: got %b need 0", bus.o_overrun); end
      if (bus.o_len_err !== 1'b0) begin n_failed++; $display("FAIL reset len_err: got %b need 0", bus.o_len_err); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_row();
      logic exp_sclk;
      do_reset();
      pulse_row(1'b1);
      for (int k = 1; k <= 2 * CLK_DIV; k++) begin
         exp_sclk = (k > CLK_DIV);
         n_tests += 3;
         if (bus.o_write_done !== 1'b0) begin n_failed++; $display("FAIL single_row write_done t%0d: got %b need 0", k, bus.o_write_done); end
         if (sclk !== exp_sclk) begin n_failed++; $display("FAIL single_row sclk t%0d: got %b need %b", k, sclk, exp_sclk); end
         if (sdata !== 1'b1) begin n_failed++; $display("FAIL single_row sdata t%0d: got %b need 1", k, sdata); end
         @(negedge clk);
      end
      n_tests += 2;
      if (bus.o_write_done !== 1'b1) begin n_failed++; $display("FAIL single_row write_done t5: got %b need 1", bus.o_write_done); end
      if (sclk !== 1'b0) begin n_failed++; $display("FAIL single_row sclk t5: got %b need 0", sclk); end
   endtask

   task automatic test_key_ok();
      logic [7:0]  rows;
      logic [15:0] b;
      int nb, lc, kc, ka;
      do_reset();
      send_rows(4, 8'b0000_1011, rows);
      n_tests++;
      if (rows[3:0] !== 4'b1011) begin n_failed++; $display("FAIL key_ok row_bits: got %b need 1011", rows[3:0]); end
      wait_idle("key_ok");
      pulse_key(4'hA);
      capture(19, b, nb, lc, kc, ka);
      n_tests += 8;
      if (nb != 4) begin n_failed++; $display("FAIL key_ok sclk_rises: got %0d need 4", nb); end
      if (b[3:0] !== 4'hA) begin n_failed++; $display("FAIL key_ok key_bits: got %h need a", b[3:0]); end
      if (lc != 2) begin n_failed++; $display("FAIL key_ok latch_cycles: got %0d need 2", lc); end
      if (kc != 1) begin n_failed++; $display("FAIL key_ok done_pulses: got %0d need 1", kc); end
      if (ka != 19) begin n_failed++; $display("FAIL key_ok done_time: got t%0d need t19", ka); end
      if (bus.o_len_err !== 1'b0) begin n_failed++; $display("FAIL key_ok len_err: got %b need 0", bus.o_len_err); end
      if (bus.o_overrun !== 1'b0) begin n_failed++; $display("FAIL key_ok overrun: got %b need 0", bus.o_overrun); end
      if (bus.o_write_done !== 1'b1) begin n_failed++; $display("FAIL key_ok write_done t20: got %b need 1", bus.o_write_done); end
   endtask

   task automatic test_len_err();
      logic [7:0]  rows;
      logic [15:0] b;
      int nb, lc, kc, ka;
      // Short frame: three rows.
      do_reset();
      send_rows(3, 8'b0000_0111, rows);
      wait_idle("len_short");
      n_tests++;
      if (bus.o_len_err !== 1'b0) begin n_failed++; $display("FAIL len_short before_key: got %b need 0", bus.o_len_err); end
      pulse_key(4'h5);
      n_tests++;
      if (bus.o_len_err !== 1'b1) begin n_failed++; $display("FAIL len_short after_key: got %b need 1", bus.o_len_err); end
      capture(19, b, nb, lc, kc, ka);
      n_tests += 3;
      if (b[3:0] !== 4'h5 || nb != 4) begin n_failed++; $display("FAIL len_short key_bits: got %h/%0d need 5/4", b[3:0], nb); end
      if (kc != 1 || ka != 19) begin n_failed++; $display("FAIL len_short done: got %0d pulses at t%0d need 1 at t19", kc, ka); end
      if (bus.o_len_err !== 1'b1) begin n_failed++; $display("FAIL len_short sticky: got %b need 1", bus.o_len_err); end
      // Long frame: five rows saturate the counter above N_ROWS.
      do_reset();
      send_rows(5, 8'b0001_0101, rows);
      wait_idle("len_long");
      pulse_key(4'h3);
      n_tests++;
      if (bus.o_len_err !== 1'b1) begin n_failed++; $display("FAIL len_long after_key: got %b need 1", bus.o_len_err); end
      capture(19, b, nb, lc, kc, ka);
      n_tests++;
      if (kc != 1) begin n_failed++; $display("FAIL len_long done_pulses: got %0d need 1", kc); end
   endtask

   task automatic test_overrun();
      logic        prev;
      int          rises;
      logic [15:0] b;
      int nb, lc, kc, ka;
      // Row request during ROW_HI.
      do_reset();
      pulse_row(1'b1);
      n_tests++;
      if (bus.o_overrun !== 1'b0) begin n_failed++; $display("FAIL overrun_busy t1: got %b need 0", bus.o_overrun); end
      prev  = 1'b0;
      rises = 0;
      for (int k = 1; k <= 6; k++) begin
         if (sclk && !prev) rises++;
         prev = sclk;
         if (k == 3) begin
            bus.i_row_wren = 1'b1;
            bus.i_row_val  = 1'b0;
         end else begin
            idle_inputs();
         end
         @(negedge clk);
      end
      n_tests += 4;
      if (rises != 1) begin n_failed++; $display("FAIL overrun_busy sclk_rises: got %0d need 1", rises); end
      if (bus.o_overrun !== 1'b1) begin n_failed++; $display("FAIL overrun_busy flag: got %b need 1", bus.o_overrun); end
      if (bus.o_write_done !== 1'b1) begin n_failed++; $display("FAIL overrun_busy write_done: got %b need 1", bus.o_write_done); end
      if (sdata !== 1'b1) begin n_failed++; $display("FAIL overrun_busy sdata: got %b need 1", sdata); end
      // Simultaneous row and key in IDLE.
      do_reset();
      bus.i_row_wren = 1'b1;
      bus.i_row_val  = 1'b1;
      bus.i_key_wren = 1'b1;
      bus.i_key      = 4'hF;
      @(negedge clk);
      idle_inputs();
      capture(19, b, nb, lc, kc, ka);
      n_tests += 5;
      if (nb != 1 || b[0] !== 1'b1) begin n_failed++; $display("FAIL overrun_both row: got %0d rises bit %b need 1 rise bit 1", nb, b[0]); end
      if (lc != 0) begin n_failed++; $display("FAIL overrun_both latch_cycles: got %0d need 0", lc); end
      if (kc != 0) begin n_failed++; $display("FAIL overrun_both done_pulses: got %0d need 0", kc); end
      if (bus.o_overrun !== 1'b1) begin n_failed++; $display("FAIL overrun_both flag: got %b need 1", bus.o_overrun); end
      if (bus.o_len_err !== 1'b0) begin n_failed++; $display("FAIL overrun_both len_err: got %b need 0", bus.o_len_err); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] b;
      int nb, lc, kc, ka;
      do_reset();
      pulse_key(4'hC);
      repeat (6) @(negedge clk);   // t7: KEY_HI of the second bit
      n_tests += 2;
      if (sclk !== 1'b1) begin n_failed++; $display("FAIL reset_mid pre_sclk: got %b need 1", sclk); end
      if (sdata !== 1'b1) begin n_failed++; $display("FAIL reset_mid pre_sdata: got %b need 1", sdata); end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests += 4;
      if (sclk !== 1'b0) begin n_failed++; $display("FAIL reset_mid sclk: got %b need 0", sclk); end
      if (sdata !== 1'b0) begin n_failed++; $display("FAIL reset_mid sdata: got %b need 0", sdata); end
      if (bus.o_write_done !== 1'b1) begin n_failed++; $display("FAIL reset_mid write_done: got %b need 1", bus.o_write_done); end
      if (latch !== 1'b0) begin n_failed++; $display("FAIL reset_mid latch: got %b need 0", latch); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      capture(20, b, nb, lc, kc, ka);
      n_tests += 2;
      if (kc != 0) begin n_failed++; $display("FAIL reset_mid done_pulses: got %0d need 0", kc); end
      if (nb != 0) begin n_failed++; $display("FAIL reset_mid sclk_rises: got %0d need 0", nb); end
      pulse_row(1'b1);
      capture(2 * CLK_DIV, b, nb, lc, kc, ka);
      n_tests += 2;
      if (nb != 1 || b[0] !== 1'b1) begin n_failed++; $display("FAIL reset_mid new_row: got %0d rises bit %b need 1 rise bit 1", nb, b[0]); end
      if (bus.o_write_done !== 1'b1) begin n_failed++; $display("FAIL reset_mid new_row_done: got %b need 1", bus.o_write_done); end
   endtask

   // ---------------------------------------------------------------------
   // Sequence
   // ---------------------------------------------------------------------
   initial begin
      idle_inputs();
      test_reset();
      test_single_row();
      test_key_ok();
      test_len_err();
      test_overrun();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule : tb_row_shift_writer
